clk_step_ctrl: RTL

- Processor clock-enable controller for the RISC-V single-cycle core.
- Sits between the 50 MHz board clock and the core, and replaces the bare divide-by-N with a sequenced source of one-cycle enable pulses.
- Modes: free-run at a programmable divide ratio, halt, or single-step from a debounced push-button.
- Also honours a halt request from the core (e.g. on EBREAK).

---
 rtl/rvsp_clk_pkg.sv | 19 +
 rtl/clk_step_ctrl_btn_debounce.sv | 71 +++++++
 rtl/clk_step_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rvsp_clk_pkg.sv
// Shared encodings and defaults for the processor clock-enable controller.
package rvsp_clk_pkg;

    // Operating mode selector values; 2'b11 is decoded as halt by the controller.
    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // Controller FSM state encodings, also exported on the STATE port.
    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10
    } state_e;

    // 10 ms of stability at a 50 MHz board clock.
    localparam int unsigned DEBOUNCE_CYC_DEFAULT = 32'd500000;

endpackage : rvsp_clk_pkg

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability-counter debouncer
// and a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
    import rvsp_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic CLK_50,
    input  logic RST,
    input  logic BTN_IN,
    output logic BTN_LEVEL,
    output logic BTN_RISE
);

    // The counter only has to reach DEBOUNCE_CYC-1, so clog2(DEBOUNCE_CYC) bits suffice.
    localparam int unsigned CW = (DEBOUNCE_CYC > 32'd1) ? $clog2(DEBOUNCE_CYC) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 32'd1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronize the raw button and accept a new level only after it has
    // disagreed with the current level for DEBOUNCE_CYC consecutive cycles.
    always_comb begin
        sync1_d     = BTN_IN;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                level_d = level_q;
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            level_d = level_q;
            cnt_d   = '0;
        end
        level_dly_d = level_q;
        rise_d      = level_q & ~level_dly_q;
    end

    // Debouncer state registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
            cnt_q       <= cnt_d;
        end
    end

    assign BTN_LEVEL = level_q;
    assign BTN_RISE  = rise_q;

endmodule : btn_debounce

// File: rtl/clk_step_ctrl.sv
// Clock-enable sequencer for the single-cycle core: free-run at DIV+1,
// halt, or single-step from the debounced push-button, with a sticky
// halt request from the core.
module clk_step_ctrl
    import rvsp_clk_pkg::*;
#(
    parameter int unsigned DIV_W        = 32'd26,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned CNT_W        = 32'd32
) (
    input  logic             CLK_50,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [DIV_W-1:0] DIV,
    input  logic             STEP_BTN,
    input  logic             HALT_REQ,
    output logic             CLK_EN,
    output logic [1:0]       STATE,
    output logic             RUNNING,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    state_e             state_q, state_d;
    logic               halt_q, halt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               clk_en_q, clk_en_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;

    logic               btn_level_s;
    logic               btn_rise_s;
    logic               step_req_s;
    logic               tick_s;
    logic               mode_run_s;
    logic               mode_step_s;
    logic               mode_halt_s;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn (
        .CLK_50    (CLK_50),
        .RST       (RST),
        .BTN_IN    (STEP_BTN),
        .BTN_LEVEL (btn_level_s),
        .BTN_RISE  (btn_rise_s)
    );

    // A step request needs the debounced level still asserted, so a press
    // that has already been released again does not count.
    assign step_req_s  = btn_rise_s & btn_level_s;

    // Mode decode: the unused encoding 2'b11 behaves as halt.
    assign mode_run_s  = (MODE == MODE_RUN);
    assign mode_step_s = (MODE == MODE_STEP);
    assign mode_halt_s = ~mode_run_s & ~mode_step_s;

    // FSM state register.
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state_q <= ST_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; leaving RUN wins over a pending tick, and a step
    // is honoured even while the halt latch is set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALTED: begin
                if (mode_run_s && !halt_q && !HALT_REQ) begin
                    state_d = ST_RUN;
                end else if (mode_step_s && step_req_s) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_RUN: begin
                if (!mode_run_s || HALT_REQ) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    // FSM outputs, registered so CLK_EN reflects the state the core sees next cycle.
    always_comb begin
        clk_en_d  = 1'b0;
        running_d = 1'b0;
        case (state_d)
            ST_RUN: begin
                clk_en_d  = tick_s;
                running_d = 1'b1;
            end
            ST_STEP: begin
                clk_en_d  = 1'b1;
                running_d = 1'b0;
            end
            default: begin
                clk_en_d  = 1'b0;
                running_d = 1'b0;
            end
        endcase
    end

    // Halt latch: core request sets it, only an explicit halt mode clears it.
    always_comb begin
        if (HALT_REQ) begin
            halt_d = 1'b1;
        end else if (mode_halt_s) begin
            halt_d = 1'b0;
        end else begin
            halt_d = halt_q;
        end
    end

    // Divider: counts in RUN only; >= compare keeps a lowered DIV from wrapping.
    always_comb begin
        div_cnt_d = '0;
        tick_s    = 1'b0;
        if (state_q == ST_RUN) begin
            if (div_cnt_q >= DIV) begin
                tick_s    = 1'b1;
                div_cnt_d = '0;
            end else begin
                tick_s    = 1'b0;
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end else begin
            tick_s    = 1'b0;
            div_cnt_d = '0;
        end
    end

    // Retired-pulse counter: each cycle with CLK_EN high adds one, wrapping naturally.
    always_comb begin
        if (clk_en_q) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
    end

    // Datapath and output registers with synchronous reset.
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            halt_q    <= 1'b0;
            div_cnt_q <= '0;
            clk_en_q  <= 1'b0;
            running_q <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            halt_q    <= halt_d;
            div_cnt_q <= div_cnt_d;
            clk_en_q  <= clk_en_d;
            running_q <= running_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign CLK_EN    = clk_en_q;
    assign STATE     = state_q;
    assign RUNNING   = running_q;
    assign CYCLE_CNT = cyc_cnt_q;

endmodule : clk_step_ctrl
